store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the MEM stage and the single-port word-addressed data memory. Stores from the pipeline are queued and written to memory in cycles when the MEM stage is not loading, so a store never blocks the memory port. Loads that hit a buffered store are forwarded from the youngest matching entry. All other loads read memory directly in the same cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- WORD_BITS, 13, word-index width; entries match on addr[WORD_BITS+1:2], the same bits the data memory decodes.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_addr  in  32  store byte address; only bits [WORD_BITS+1:2] are kept.
- st_data  in  32  store word.
- st_ready  out  1  store accepted this cycle; equals !full.
- ld_valid  in  1  MEM stage presents a load this cycle.
- ld_addr  in  32  load byte address.
- ld_data  out  32  load result, combinational, valid in the same cycle as ld_valid; 0 when ld_valid=0.
- fwd_hit  out  1  ld_data was sourced from the buffer; 0 when ld_valid=0.
- empty  out  1  no entries are pending, for halt and sync logic.
- mem_read  out  1  connects to the memory MemRead.
- mem_write  out  1  connects to the memory MemWrite.
- mem_addr  out  32  connects to the memory Address.
- mem_wdata  out  32  connects to the memory Write_data.
- mem_rdata  in  32  connects to the memory Read_data; combinational read.

## Operation
- Storage is a circular FIFO: entry arrays addr/data[DEPTH], head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and count of log2(DEPTH)+1 bits.
- Push: a push happens when st_valid && st_ready. It writes {st_addr word index, st_data} at tail, then tail+1 and count+1.
- Drain: drain_en = !empty && !ld_valid.
  - mem_write = drain_en.
  - mem_addr = the head entry's word index shifted left by 2.
  - mem_wdata = the head entry's data.
  - At the clock edge: head+1 and count-1. The memory commits the write at the same edge.
- Load path:
  - mem_read = ld_valid.
  - When ld_valid=1: mem_addr = ld_addr and mem_write = 0. Loads always own the port.
  - Forwarding: ld_addr[WORD_BITS+1:2] is compared with every valid entry. If any entry matches, ld_data = data of the youngest match, scanning from tail-1 back to head, and fwd_hit=1.
  - If no entry matches: ld_data = mem_rdata and fwd_hit=0.
- Push and drain in the same cycle: count is unchanged and both pointers advance.
- Full (count==DEPTH): st_ready=0. The pipeline stalls and holds the store. No bypass into a full buffer, even if a drain happens that cycle.
- st_valid and ld_valid both high (illegal):
  - The load is served from the pre-push contents.
  - The store is pushed if st_ready=1.
  - No drain happens that cycle.
- Stores to the same word are all kept in order; there is no merging. They drain oldest first, so the final memory value is the youngest store.
- Idle with entries pending: the buffer drains one entry per cycle until empty.

## Timing
- Reset values: head=0, tail=0, count=0, so empty=1, st_ready=1, mem_write=0. The buffered stores in the arrays are discarded and never written to memory.
  - The array contents themselves are not cleared.
  - Combinational outputs follow the inputs: mem_read=ld_valid, fwd_hit=0, ld_data=ld_valid ? mem_rdata : 0.
- Reset asserted while entries are pending: the next cycle shows count=0. No mem_write occurs in the reset cycle.
- Forwarding visibility: a store pushed at edge N is visible to loads from cycle N+1 onward.
- Drain latency: an entry pushed at edge N reaches memory no earlier than edge N+1. It is written at the first edge after which it is head and the cycle has ld_valid=0.
- Load latency is 0 cycles; ld_data is combinational from ld_addr, the entry arrays and mem_rdata.
- st_ready depends only on registered count, with no combinational path from st_valid or ld_valid.

## Test plan
- Reset, then push stores 0x10←0xA, 0x14←0xB with ld_valid=0 throughout -> mem_write pulses at 0x10 and then 0x14 on the next two edges, and empty=1 afterwards.
- Push 0x20←0x11 and then 0x20←0x22, then load 0x20 -> ld_data=0x22 with fwd_hit=1. After draining, a load of 0x20 returns 0x22 from memory with fwd_hit=0.
- Hold ld_valid=1 to unrelated addresses while pushing 5 stores -> after the 4th push st_ready=0 and mem_write=0 throughout. After ld_valid drops, one drain occurs per cycle and st_ready=1 after the first drain.
- Load 0x30 with no matching entry while memory holds 0x77 there -> ld_data=0x77, fwd_hit=0, and no drain that cycle.
- Push 3 stores, then assert reset for one cycle -> empty=1 and st_ready=1 on the next cycle, with no mem_write in or after the reset cycle.
- Wrap-around: with DEPTH=4, run 10 interleaved push/drain cycles, including simultaneous push and drain -> memory contents match a reference model in order and count never exceeds 4.

Source files
------------

// File: rtl/store_buffer_if.sv
// Pipeline/memory-facing bus of the store buffer: store push, load lookup and data-memory port.
interface store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        fwd_hit;
    logic        empty;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        input  st_ready, ld_data, fwd_hit, empty, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        output st_ready, ld_data, fwd_hit, empty, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM stage and data memory; loads forward from youngest match, 0-cycle.
// Drains one entry per cycle when no load owns the port; st_ready = !full, no bypass into a full buffer.
module store_buffer #(
    parameter int DEPTH     = 4,
    parameter int WORD_BITS = 13
) (
    input logic            clk,
    input logic            reset,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WORD_BITS-1:0] addr_q [DEPTH];
    logic [31:0]          data_q [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        count;

    logic                 full;
    logic                 is_empty;
    logic                 push;
    logic                 drain;
    logic [WORD_BITS-1:0] st_widx;
    logic [WORD_BITS-1:0] ld_widx;
    logic                 fwd_found;
    logic [31:0]          fwd_data;
    logic [PW-1:0]        idx;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.st_addr[31:WORD_BITS+2], bus.st_addr[1:0],
                                bus.ld_addr[31:WORD_BITS+2], bus.ld_addr[1:0]};

    assign full     = (count == FULL_CNT);
    assign is_empty = (count == '0);
    assign st_widx  = bus.st_addr[WORD_BITS+1:2];
    assign ld_widx  = bus.ld_addr[WORD_BITS+1:2];

    // Full is judged on registered count only, so a same-cycle drain never frees a slot for the store.
    assign push  = bus.st_valid && !full && !reset;
    assign drain = !is_empty && !bus.ld_valid && !reset;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_found = 1'b0;
        fwd_data  = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr_q[idx] == ld_widx)) begin
                fwd_found = 1'b1;
                fwd_data  = data_q[idx];
            end
        end
    end

    assign bus.st_ready  = !full;
    assign bus.empty     = is_empty;
    assign bus.mem_read  = bus.ld_valid;
    assign bus.mem_write = drain;
    assign bus.mem_addr  = bus.ld_valid ? bus.ld_addr
                                        : {{(30-WORD_BITS){1'b0}}, addr_q[head], 2'b00};
    assign bus.mem_wdata = data_q[head];
    assign bus.fwd_hit   = bus.ld_valid && fwd_found;
    assign bus.ld_data   = !bus.ld_valid ? 32'h0 : (fwd_found ? fwd_data : bus.mem_rdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)  tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is never cleared; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_widx;
            data_q[tail] <= bus.st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based posted-write model.
module tb_store_buffer;
    logic clk = 1'b0;
    logic reset;
    store_buffer_if bus ();

    store_buffer #(.DEPTH(4), .WORD_BITS(13)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem   [0:8191];
    logic [31:0] refmem [0:8191];

    assign bus.mem_rdata = dmem[bus.mem_addr[14:2]];
    always @(posedge clk) if (bus.mem_write === 1'b1) dmem[bus.mem_addr[14:2]] <= bus.mem_wdata;

    typedef struct { bit [12:0] a; bit [31:0] d; } entry_t;
    entry_t q[$];

    int checks = 0;
    int errors = 0;

    bit        cur_sv, cur_lv, cur_rs;
    bit [31:0] cur_sa, cur_sd, cur_la;
    bit        exp_ready, exp_empty, exp_hit, exp_wr;
    bit [31:0] exp_ld, exp_maddr, exp_wdata;

    function automatic void model_eval();
        exp_ready = (q.size() < 4);
        exp_empty = (q.size() == 0);
        exp_wr    = !cur_lv && (q.size() > 0) && !cur_rs;
        exp_hit   = 1'b0;
        exp_ld    = 32'h0;
        exp_wdata = (q.size() > 0) ? q[0].d : 32'h0;
        exp_maddr = cur_lv ? cur_la : ((q.size() > 0) ? {17'h0, q[0].a, 2'b00} : 32'h0);
        if (cur_lv) begin
            exp_ld = refmem[cur_la[14:2]];
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a == cur_la[14:2]) begin
                    exp_hit = 1'b1;
                    exp_ld  = q[i].d;
                    break;
                end
            end
        end
    endfunction

    function automatic void model_update();
        bit     pre_ready;
        entry_t e;
        pre_ready = (q.size() < 4);
        if (cur_rs) begin
            q.delete();
        end else begin
            if (exp_wr) begin
                refmem[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (cur_sv && pre_ready) begin
                e.a = cur_sa[14:2];
                e.d = cur_sd;
                q.push_back(e);
            end
        end
    endfunction

    task automatic drive(input bit sv, input bit [31:0] sa, input bit [31:0] sd,
                         input bit lv, input bit [31:0] la, input bit rs);
        cur_sv = sv; cur_sa = sa; cur_sd = sd; cur_lv = lv; cur_la = la; cur_rs = rs;
        bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd;
        bus.ld_valid = lv; bus.ld_addr = la; reset = rs;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
        checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.st_ready); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", bus.mem_write); end
        checks++; if (bus.ld_data !== 32'h0 || bus.fwd_hit !== 1'b0 || bus.mem_read !== 1'b0) begin
            errors++; $display("FAIL rst_idle_ld: data %h hit %b rd %b want 0 0 0", bus.ld_data, bus.fwd_hit, bus.mem_read);
        end
        drive(0, 0, 0, 1, 32'h40, 0);
        checks++; if (bus.ld_data !== refmem[16] || bus.fwd_hit !== 1'b0 || bus.mem_read !== 1'b1) begin
            errors++; $display("FAIL rst_ld: data %h hit %b rd %b want %h 0 1", bus.ld_data, bus.fwd_hit, bus.mem_read, refmem[16]);
        end
        tick();
    endtask

    task automatic test_drain_basic();
        drive(1, 32'h10, 32'hA, 0, 0, 0);
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL drain_first_wr: got %b want 0", bus.mem_write); end
        tick();
        drive(1, 32'h14, 32'hB, 0, 0, 0);
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hA) begin
            errors++; $display("FAIL drain_0x10: wr %b addr %h data %h want 1 10 a", bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h14 || bus.mem_wdata !== 32'hB) begin
            errors++; $display("FAIL drain_0x14: wr %b addr %h data %h want 1 14 b", bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.empty !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL drain_done: empty %b wr %b want 1 0", bus.empty, bus.mem_write);
        end
        checks++; if (dmem[4] !== 32'hA || dmem[5] !== 32'hB) begin
            errors++; $display("FAIL drain_mem: got %h %h want a b", dmem[4], dmem[5]);
        end
        tick();
    endtask

    task automatic test_forward();
        drive(1, 32'h20, 32'h11, 0, 0, 0); tick();
        drive(1, 32'h20, 32'h22, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 32'h20, 0);
        checks++; if (bus.ld_data !== 32'h22 || bus.fwd_hit !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL fwd_young: data %h hit %b wr %b want 22 1 0", bus.ld_data, bus.fwd_hit, bus.mem_write);
        end
        tick();
        drain_all();
        drive(0, 0, 0, 1, 32'h20, 0);
        checks++; if (bus.ld_data !== 32'h22 || bus.fwd_hit !== 1'b0) begin
            errors++; $display("FAIL fwd_mem: data %h hit %b want 22 0", bus.ld_data, bus.fwd_hit);
        end
        tick();
        // Load held high keeps all three stores buffered so two entries share a word.
        drive(1, 32'h24, 32'h1, 1, 32'h200, 0); tick();
        drive(1, 32'h28, 32'h2, 1, 32'h200, 0); tick();
        drive(1, 32'h24, 32'h3, 1, 32'h200, 0); tick();
        drive(0, 0, 0, 1, 32'h24, 0);
        checks++; if (bus.ld_data !== 32'h3 || bus.fwd_hit !== 1'b1) begin
            errors++; $display("FAIL fwd_multi: data %h hit %b want 3 1", bus.ld_data, bus.fwd_hit);
        end
        tick();
        drain_all();
        checks++; if (dmem[9] !== 32'h3 || dmem[10] !== 32'h2) begin
            errors++; $display("FAIL fwd_order: got %h %h want 3 2", dmem[9], dmem[10]);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h40 + 32'(4 * k), 32'h100 + 32'(k), 1, 32'h300, 0);
            checks++; if (bus.st_ready !== (k < 4) || bus.mem_write !== 1'b0) begin
                errors++; $display("FAIL full_fill%0d: ready %b wr %b want %b 0", k, bus.st_ready, bus.mem_write, k < 4);
            end
            tick();
        end
        drive(1, 32'h50, 32'h999, 0, 0, 0);
        checks++; if (bus.st_ready !== 1'b0 || bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h40) begin
            errors++; $display("FAIL full_nobypass: ready %b wr %b addr %h want 0 1 40", bus.st_ready, bus.mem_write, bus.mem_addr);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++; if (bus.st_ready !== exp_ready || bus.mem_write !== exp_wr || bus.empty !== exp_empty) begin
                errors++; $display("FAIL full_drain%0d: ready %b wr %b empty %b want %b %b %b", k,
                                   bus.st_ready, bus.mem_write, bus.empty, exp_ready, exp_wr, exp_empty);
            end
            tick();
        end
        checks++; if (dmem[16] !== 32'h100 || dmem[19] !== 32'h103 || dmem[20] !== refmem[20]) begin
            errors++; $display("FAIL full_mem: got %h %h %h want 100 103 %h", dmem[16], dmem[19], dmem[20], refmem[20]);
        end
    endtask

    task automatic test_load_miss();
        dmem[12] = 32'h77; refmem[12] = 32'h77;
        drive(1, 32'h60, 32'h5, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 32'h30, 0);
        checks++; if (bus.ld_data !== 32'h77 || bus.fwd_hit !== 1'b0 || bus.mem_write !== 1'b0
                      || bus.mem_addr !== 32'h30 || bus.mem_read !== 1'b1) begin
            errors++; $display("FAIL miss_ld: data %h hit %b wr %b addr %h rd %b want 77 0 0 30 1",
                               bus.ld_data, bus.fwd_hit, bus.mem_write, bus.mem_addr, bus.mem_read);
        end
        tick();
        drain_all();
    endtask

    task automatic test_reset_pending();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h70 + 32'(4 * k), 32'hE0 + 32'(k), 1, 32'h300, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rstp_wr: got %b want 0", bus.mem_write); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.empty !== 1'b1 || bus.st_ready !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL rstp_after: empty %b ready %b wr %b want 1 1 0", bus.empty, bus.st_ready, bus.mem_write);
        end
        tick();
        checks++; if (dmem[28] !== refmem[28] || dmem[29] !== refmem[29] || dmem[30] !== refmem[30]) begin
            errors++; $display("FAIL rstp_mem: got %h %h %h want %h %h %h", dmem[28], dmem[29], dmem[30],
                               refmem[28], refmem[29], refmem[30]);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int c = 0; c < 120; c++) begin
            bit sv, lv;
            sv = ($urandom_range(0, 2) != 0);
            lv = ($urandom_range(0, 2) == 0);
            drive(sv, 32'h80 + 32'(4 * $urandom_range(0, 3)), $urandom, lv,
                  32'h80 + 32'(4 * $urandom_range(0, 4)), 0);
            checks++;
            if (bus.st_ready !== exp_ready || bus.empty !== exp_empty || bus.mem_write !== exp_wr
                || bus.mem_read !== lv || bus.fwd_hit !== exp_hit || bus.ld_data !== exp_ld
                || ((lv || exp_wr) && bus.mem_addr !== exp_maddr)
                || (exp_wr && bus.mem_wdata !== exp_wdata)) begin
                errors++;
                $display("FAIL rand_c%0d: rdy %b emp %b wr %b hit %b ld %h addr %h wd %h want %b %b %b %b %h %h %h",
                         c, bus.st_ready, bus.empty, bus.mem_write, bus.fwd_hit, bus.ld_data, bus.mem_addr,
                         bus.mem_wdata, exp_ready, exp_empty, exp_wr, exp_hit, exp_ld, exp_maddr, exp_wdata);
            end
            tick();
        end
        drain_all();
        bad = 0;
        for (int i = 0; i < 8192; i++) if (dmem[i] !== refmem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_mem: %0d words differ, want 0", bad); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rand_empty: got %b want 1", bus.empty); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            dmem[i]   = $urandom;
            refmem[i] = dmem[i];
        end
        test_reset();
        test_drain_basic();
        test_forward();
        test_full();
        test_load_miss();
        test_reset_pending();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
